// File: rtl/serial_sum_ctrl_pkg.sv
// Shared definitions for the serial operand summation controller:
// FSM state encoding and the operand-counter width helper.
package serial_sum_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // OpCount has to represent 0..num_ops inclusive.
   function automatic int opcnt_width(input int num_ops);
      return $clog2(num_ops + 1);
   endfunction

endpackage

// File: rtl/serial_sum_ctrl_if.sv
// Operand stream, control and result bundle of serial_sum_ctrl.
// master = operand source / consumer side, slave = the controller.
interface serial_sum_ctrl_if
   import serial_sum_ctrl_pkg::*;
#(
   parameter int NUM_OPS   = 16,
   parameter int INWIDTH   = 8,
   parameter int DATAWIDTH = 32
);
   localparam int CNTW = opcnt_width(NUM_OPS);

   logic                 Start;
   logic [NUM_OPS-1:0]   SkipMask;
   logic                 Abort;
   logic [INWIDTH-1:0]   InData;
   logic                 InValid;
   logic                 InReady;
   logic [DATAWIDTH-1:0] Final;
   logic                 Done;
   logic                 Busy;
   logic [CNTW-1:0]      OpCount;

   modport master (
      output Start, SkipMask, Abort, InData, InValid,
      input  InReady, Final, Done, Busy, OpCount
   );

   modport slave (
      input  Start, SkipMask, Abort, InData, InValid,
      output InReady, Final, Done, Busy, OpCount
   );

endinterface

// File: rtl/serial_sum_ctrl_add.sv
// Shared combinational adder; unsigned, wraps modulo 2^DATAWIDTH.
module add #(
   parameter int DATAWIDTH = 32
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic [DATAWIDTH-1:0] sum
);

   // Plain wrap-around add; the carry out is intentionally discarded.
   assign sum = a + b;

endmodule

// File: rtl/serial_sum_ctrl.sv
// Time-multiplexed operand summation: one shared adder accumulates a
// stream of NUM_OPS operands, with per-slot skip mask latched at Start.
module serial_sum_ctrl
   import serial_sum_ctrl_pkg::*;
#(
   parameter int NUM_OPS   = 16,
   parameter int INWIDTH   = 8,
   parameter int DATAWIDTH = 32
) (
   input logic              Clk,
   input logic              Rst,
   serial_sum_ctrl_if.slave bus
);

   localparam int CNTW = opcnt_width(NUM_OPS);
   localparam int IDXW = $clog2(NUM_OPS);
   localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NUM_OPS - 1);

   state_e               state_q, state_d;
   logic [DATAWIDTH-1:0] acc_q, acc_d;
   logic [DATAWIDTH-1:0] final_q, final_d;
   logic [NUM_OPS-1:0]   mask_q, mask_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 inready_q, inready_d;

   logic                 xfer_s;
   logic                 skip_s;
   logic [DATAWIDTH-1:0] operand_s;
   logic [DATAWIDTH-1:0] add_sum_s;
   logic [DATAWIDTH-1:0] acc_next_s;

   // Transfer qualification uses the registered ready so it matches what the source sees.
   assign xfer_s     = bus.InValid & inready_q;
   assign skip_s     = mask_q[cnt_q[IDXW-1:0]];
   assign operand_s  = DATAWIDTH'(bus.InData);
   assign acc_next_s = skip_s ? acc_q : add_sum_s;

   add #(
      .DATAWIDTH(DATAWIDTH)
   ) u_add (
      .a   (acc_q),
      .b   (operand_s),
      .sum (add_sum_s)
   );

   // Next-state, datapath and output decode; outputs follow the next state so they come straight from flops.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      final_d = final_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            // Start beats a simultaneous Abort here: Abort only acts in ACCUM.
            if (bus.Start) begin
               state_d = ST_ACCUM;
               acc_d   = {DATAWIDTH{1'b0}};
               cnt_d   = CNT_ZERO;
               mask_d  = bus.SkipMask;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (bus.Abort) begin
               // Abort wins over a same-cycle transfer; the operand is dropped.
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (xfer_s) begin
               acc_d = acc_next_s;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  // Load Final on entry so it is valid in the Done cycle.
                  state_d = ST_DONE;
                  final_d = acc_next_s;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      inready_d = (state_d == ST_ACCUM);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
   end

   // State, datapath and output registers; Rst returns everything to idle values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= {DATAWIDTH{1'b0}};
         final_q   <= {DATAWIDTH{1'b0}};
         mask_q    <= {NUM_OPS{1'b0}};
         cnt_q     <= CNT_ZERO;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         inready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         final_q   <= final_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         inready_q <= inready_d;
      end
   end

   assign bus.InReady = inready_q;
   assign bus.Final   = final_q;
   assign bus.Done    = done_q;
   assign bus.Busy    = busy_q;
   assign bus.OpCount = cnt_q;

endmodule

// File: tb/tb_serial_sum_ctrl.sv
// Directed bench for serial_sum_ctrl: table of full summation runs plus
// hand-written abort, reset-mid-run and narrow-width wrap sequences.
module tb_serial_sum_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   serial_sum_ctrl_if #(.NUM_OPS(16), .INWIDTH(8), .DATAWIDTH(32)) bus ();
   serial_sum_ctrl #(.NUM_OPS(16), .INWIDTH(8), .DATAWIDTH(32)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   serial_sum_ctrl_if #(.NUM_OPS(4), .INWIDTH(8), .DATAWIDTH(8)) bus_w ();
   serial_sum_ctrl #(.NUM_OPS(4), .INWIDTH(8), .DATAWIDTH(8)) dut_w (
      .Clk (clk),
      .Rst (rst),
      .bus (bus_w)
   );

   typedef struct {
      logic [15:0] mask;
      logic [7:0]  base;
      logic [7:0]  step;
      int          gap;
      bit          start_abort;
      bit          mid_start;
      logic [31:0] exp_final;
      int          exp_edges;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // One complete run on the 16-operand instance; edges counted from the Start edge.
   task automatic run_vec(input vec_t v, input string nm);
      int edges = 0;
      int k = 0;
      bit seen = 1'b0;
      @(negedge clk);
      bus.Start    = 1'b1;
      bus.Abort    = v.start_abort;
      bus.SkipMask = v.mask;
      bus.InValid  = 1'b0;
      @(posedge clk);
      while (!seen && edges < 200) begin
         @(negedge clk);
         if (bus.Done) begin
            seen = 1'b1;
         end else begin
            bus.Start    = v.mid_start && (edges == 4);
            bus.Abort    = 1'b0;
            bus.SkipMask = ~v.mask;
            if (v.gap == 0 || (edges % 2) == 0) begin
               bus.InValid = 1'b1;
               bus.InData  = 8'(v.base + v.step * k);
               k++;
            end else begin
               bus.InValid = 1'b0;
               bus.InData  = 8'hEE;
            end
            @(posedge clk);
            edges++;
         end
      end
      bus.InValid = 1'b0;
      bus.Start   = 1'b0;
      chk({nm, " done_seen"}, 32'(seen), 32'd1);
      chk({nm, " done_edges"}, 32'(edges), 32'(v.exp_edges));
      chk({nm, " final"}, bus.Final, v.exp_final);
      chk({nm, " opcount"}, 32'(bus.OpCount), 32'd16);
      chk({nm, " busy_at_done"}, 32'(bus.Busy), 32'd1);
      chk({nm, " inready_at_done"}, 32'(bus.InReady), 32'd0);
      @(negedge clk);
      chk({nm, " done_one_cycle"}, 32'(bus.Done), 32'd0);
      chk({nm, " busy_after"}, 32'(bus.Busy), 32'd0);
      chk({nm, " final_held"}, bus.Final, v.exp_final);
   endtask

   initial begin
      int   edges;
      bit   seen;
      vec_t clean;
      logic [7:0] wops [4];

      tbl[0] = '{16'h0000, 8'h01, 8'h01, 0, 1'b0, 1'b0, 32'd136,  16};
      tbl[1] = '{16'h0800, 8'hFF, 8'h00, 0, 1'b0, 1'b0, 32'd3825, 16};
      tbl[2] = '{16'h0000, 8'h10, 8'h00, 1, 1'b0, 1'b0, 32'd256,  31};
      tbl[3] = '{16'hFFFF, 8'h55, 8'h00, 0, 1'b0, 1'b0, 32'd0,    16};
      tbl[4] = '{16'hAAAA, 8'h01, 8'h01, 0, 1'b1, 1'b0, 32'd64,   16};
      tbl[5] = '{16'h8000, 8'h01, 8'h01, 0, 1'b0, 1'b1, 32'd120,  16};
      clean  = '{16'h0000, 8'h02, 8'h00, 0, 1'b0, 1'b0, 32'd32,   16};
      wops[0] = 8'd200; wops[1] = 8'd100; wops[2] = 8'd0; wops[3] = 8'd1;

      rst = 1'b1;
      bus.Start = 1'b0; bus.SkipMask = 16'h0000; bus.Abort = 1'b0;
      bus.InData = 8'h00; bus.InValid = 1'b0;
      bus_w.Start = 1'b0; bus_w.SkipMask = 4'h0; bus_w.Abort = 1'b0;
      bus_w.InData = 8'h00; bus_w.InValid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset final", bus.Final, 32'd0);
      chk("reset done", 32'(bus.Done), 32'd0);
      chk("reset busy", 32'(bus.Busy), 32'd0);
      chk("reset inready", 32'(bus.InReady), 32'd0);
      chk("reset opcount", 32'(bus.OpCount), 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // Abort pulsed together with a valid operand at OpCount 5.
      run_vec(tbl[0], "pre_abort");
      @(negedge clk);
      bus.Start = 1'b1; bus.SkipMask = 16'h0000;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.Start = 1'b0; bus.InValid = 1'b1; bus.InData = 8'(i + 1);
         @(posedge clk);
      end
      @(negedge clk);
      chk("abort opcount_before", 32'(bus.OpCount), 32'd5);
      bus.InData = 8'd6; bus.Abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.Abort = 1'b0; bus.InValid = 1'b0;
      chk("abort busy", 32'(bus.Busy), 32'd0);
      chk("abort inready", 32'(bus.InReady), 32'd0);
      chk("abort opcount", 32'(bus.OpCount), 32'd0);
      chk("abort done", 32'(bus.Done), 32'd0);
      chk("abort final_kept", bus.Final, 32'd136);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.Done) seen = 1'b1;
      end
      chk("abort no_late_done", 32'(seen), 32'd0);
      run_vec(clean, "after_abort");

      // Rst asserted mid-run at OpCount 7.
      @(negedge clk);
      bus.Start = 1'b1; bus.SkipMask = 16'h0000;
      @(posedge clk);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.Start = 1'b0; bus.InValid = 1'b1; bus.InData = 8'd9;
         @(posedge clk);
      end
      @(negedge clk);
      chk("rst opcount_before", 32'(bus.OpCount), 32'd7);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; bus.InValid = 1'b0;
      chk("rst final", bus.Final, 32'd0);
      chk("rst busy", 32'(bus.Busy), 32'd0);
      chk("rst inready", 32'(bus.InReady), 32'd0);
      chk("rst opcount", 32'(bus.OpCount), 32'd0);
      chk("rst done", 32'(bus.Done), 32'd0);

      // Narrow instance: 200+100+0+1 wraps to 45 in 8 bits.
      @(negedge clk);
      bus_w.Start = 1'b1; bus_w.SkipMask = 4'h0;
      @(posedge clk);
      edges = 0; seen = 1'b0;
      while (!seen && edges < 50) begin
         @(negedge clk);
         if (bus_w.Done) begin
            seen = 1'b1;
         end else begin
            bus_w.Start   = 1'b0;
            bus_w.InValid = (edges < 4);
            bus_w.InData  = (edges < 4) ? wops[edges] : 8'h00;
            @(posedge clk);
            edges++;
         end
      end
      bus_w.InValid = 1'b0;
      chk("wrap done_seen", 32'(seen), 32'd1);
      chk("wrap done_edges", 32'(edges), 32'd4);
      chk("wrap final", 32'(bus_w.Final), 32'd45);
      chk("wrap opcount", 32'(bus_w.OpCount), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
